// File: rtl/imem_loader.sv
// Instruction-memory loader: packs a big-endian byte stream into 32-bit words
// and writes them to consecutive word addresses while holding the core stalled.
module imem_loader #(
  parameter int          DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          CNT_W     = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_words,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             we,
  output logic [31:0]      waddr,
  output logic [31:0]      wd,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] words_written
);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  state_t           state, state_n;
  logic [CNT_W-1:0] len;
  logic [1:0]       byte_idx;
  logic [23:0]      shift;
  logic             accept;
  logic             start_ok;
  logic             last_byte;
  logic [CNT_W-1:0] ww_inc;

  assign accept    = (state == RECV) && in_valid && in_ready;
  assign start_ok  = start && ((state == IDLE) || (state == DONE));
  assign last_byte = accept && (byte_idx == 2'd3);
  assign ww_inc    = words_written + 1'b1;

  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: begin
        if (start_ok) begin
          if ((num_words == '0) || (num_words > DEPTH_C)) state_n = DONE;
          else                                           state_n = RECV;
        end
      end
      RECV:    if (last_byte) state_n = WRITE;
      WRITE:   state_n = (ww_inc == len) ? DONE : RECV;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      in_ready      <= 1'b0;
      we            <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      waddr         <= '0;
      wd            <= '0;
      words_written <= '0;
      byte_idx      <= '0;
      len           <= '0;
    end else begin
      state    <= state_n;
      in_ready <= (state_n == RECV);
      we       <= (state_n == WRITE);
      busy     <= (state_n == RECV) || (state_n == WRITE);
      done     <= (state_n == DONE);
      if (start_ok) begin
        len           <= num_words;
        words_written <= '0;
        err           <= (num_words > DEPTH_C);
        byte_idx      <= '0;
      end
      if (accept) begin
        byte_idx <= byte_idx + 2'd1;
      end
      if (last_byte) begin
        wd    <= {shift, in_data};
        waddr <= BASE_ADDR + (32'(words_written) << 2);
      end
      if (state == WRITE) begin
        words_written <= ww_inc;
      end
    end
  end

  // Byte assembly buffer; only the byte index decides which bytes count.
  always_ff @(posedge clk) begin
    if (accept) shift <= {shift[15:0], in_data};
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized and directed bench for imem_loader, scored against a byte-list model
// of the expected memory writes.
module tb_imem_loader;

  localparam int CNT_W = 7;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [CNT_W-1:0] num_words;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_ready;
  logic             we;
  logic [31:0]      waddr;
  logic [31:0]      wd;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] words_written;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int cyc_start = 0;
  logic [63:0] wq[$];
  logic prev_we = 1'b0;

  imem_loader #(.DEPTH(64), .BASE_ADDR(32'h0000_0000), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .num_words(num_words),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .we(we), .waddr(waddr), .wd(wd), .busy(busy), .done(done), .err(err),
    .words_written(words_written)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write monitor: collects every write and checks its handshake properties.
  always @(negedge clk) begin
    if (we) begin
      wq.push_back({waddr, wd});
      check("wr_in_ready_low", {63'd0, in_ready}, 64'd0);
      check("we_single_cycle", {63'd0, prev_we}, 64'd0);
    end
    prev_we = we;
  end

  task automatic do_start(input logic [CNT_W-1:0] nw);
    @(negedge clk);
    start = 1'b1;
    num_words = nw;
    @(negedge clk);
    start = 1'b0;
    cyc_start = cyc;
  endtask

  // mode 0: valid always, 1: valid every other cycle, 2: random gaps
  task automatic send(input logic [7:0] b[$], input int mode);
    int idx = 0;
    int n = 0;
    logic v, rdy;
    while (idx < b.size() && n < 2000) begin
      v = (mode == 0) ? 1'b1 : (mode == 1) ? ((n % 2) == 0) : ($urandom_range(0, 9) < 7);
      in_valid = v;
      in_data = b[idx];
      rdy = in_ready;
      @(negedge clk);
      n++;
      if (v && rdy) idx++;
    end
    in_valid = 1'b0;
    if (idx < b.size()) check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!done && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!done) check("done_timeout", 64'd0, 64'd1);
  endtask

  // Model: word i is bytes 4i..4i+3 big-endian, written at byte address 4i.
  task automatic check_writes(input string tag, input logic [7:0] b[$]);
    int nw = b.size() / 4;
    logic [31:0] ew;
    check({tag, "_nwrites"}, 64'(wq.size()), 64'(nw));
    for (int i = 0; i < nw && i < wq.size(); i++) begin
      ew = {b[4*i], b[4*i+1], b[4*i+2], b[4*i+3]};
      check({tag, "_addr"}, {32'd0, wq[i][63:32]}, 64'(32'(4 * i)));
      check({tag, "_data"}, {32'd0, wq[i][31:0]}, {32'd0, ew});
    end
  endtask

  logic [7:0] basic[$] = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A,
                           8'h01, 8'h09, 8'h50, 8'h20};

  initial begin
    logic [7:0] b[$];
    logic [7:0] tail[$];
    int nw;
    reset = 1'b1; start = 1'b0; num_words = '0; in_valid = 1'b0; in_data = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_err", {63'd0, err}, 64'd0);
    check("rst_ww", 64'(words_written), 64'd0);
    reset = 1'b0;

    // Basic load
    wq.delete();
    do_start(7'd3);
    check("basic_busy", {63'd0, busy}, 64'd1);
    send(basic, 0);
    wait_done(50);
    check("basic_latency", 64'(cyc - cyc_start), 64'd15);
    check_writes("basic", basic);
    check("basic_ww", 64'(words_written), 64'd3);
    check("basic_busy_off", {63'd0, busy}, 64'd0);

    // Backpressure
    wq.delete();
    do_start(7'd3);
    send(basic, 1);
    wait_done(50);
    check_writes("bp", basic);
    check("bp_ww", 64'(words_written), 64'd3);

    // Zero length
    wq.delete();
    do_start(7'd0);
    check("zero_done", {63'd0, done}, 64'd1);
    check("zero_in_ready", {63'd0, in_ready}, 64'd0);
    repeat (3) @(negedge clk);
    check("zero_in_ready_later", {63'd0, in_ready}, 64'd0);
    check("zero_nwrites", 64'(wq.size()), 64'd0);

    // Overrange, then a valid start clears err
    do_start(7'd65);
    check("ovr_err", {63'd0, err}, 64'd1);
    check("ovr_done", {63'd0, done}, 64'd1);
    repeat (2) @(negedge clk);
    check("ovr_nwrites", 64'(wq.size()), 64'd0);
    check("ovr_err_held", {63'd0, err}, 64'd1);
    do_start(7'd1);
    check("ovr_err_clear", {63'd0, err}, 64'd0);
    b = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send(b, 0);
    wait_done(50);
    check_writes("ovr_after", b);

    // Start during RECV is ignored; second load restarts at address 0
    wq.delete();
    b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    do_start(7'd2);
    send(b[0:1], 0);
    do_start(7'd5);
    check("ign_busy", {63'd0, busy}, 64'd1);
    send(b[2:7], 0);
    wait_done(50);
    check_writes("ign", b);
    check("ign_ww", 64'(words_written), 64'd2);
    wq.delete();
    b = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3};
    do_start(7'd2);
    send(b, 2);
    wait_done(100);
    check_writes("restart", b);
    check("restart_ww", 64'(words_written), 64'd2);

    // Reset mid-load
    wq.delete();
    do_start(7'd2);
    tail = '{8'hC1, 8'hC2};
    send(tail, 0);
    reset = 1'b1;
    start = 1'b1;
    num_words = 7'd1;
    @(negedge clk);
    start = 1'b0;
    check("mrst_in_ready", {63'd0, in_ready}, 64'd0);
    check("mrst_busy", {63'd0, busy}, 64'd0);
    check("mrst_done", {63'd0, done}, 64'd0);
    check("mrst_we", {63'd0, we}, 64'd0);
    check("mrst_waddr_wd", {waddr, wd}, 64'd0);
    check("mrst_ww", 64'(words_written), 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("mrst_nwrites", 64'(wq.size()), 64'd0);
    b = '{8'h12, 8'h34, 8'h56, 8'h78};
    do_start(7'd1);
    send(b, 0);
    wait_done(50);
    check_writes("mrst_after", b);

    // Randomized loads
    for (int t = 0; t < 8; t++) begin
      wq.delete();
      b.delete();
      nw = $urandom_range(1, 8);
      for (int i = 0; i < 4 * nw; i++) b.push_back(8'($urandom));
      do_start(CNT_W'(nw));
      send(b, 2);
      wait_done(100);
      check_writes("rand", b);
      check("rand_ww", 64'(words_written), 64'(nw));
      check("rand_done", {63'd0, done}, 64'd1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Writer side of the instruction memory. Receives a big-endian byte stream over a valid/ready interface and packs each group of 4 bytes into a 32-bit word. Each packed word is written to consecutive word addresses starting at BASE_ADDR. While loading, the block holds the processor core stalled. On completion it reports done, or err if the requested length is out of range.

Parameters:
DEPTH, 64, instruction memory size in 32-bit words; the maximum load length.
BASE_ADDR, 32'h0000_0000, byte address of the first word written.
CNT_W, 7, width of word counters; must satisfy 2^CNT_W > DEPTH.

Ports:
clk  input  1  clock; everything updates on the rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  one-cycle pulse; begins a load in IDLE or DONE, ignored otherwise.
num_words  input  CNT_W  word count to load; sampled on the accepted start.
in_valid  input  1  byte available on in_data.
in_data  input  8  stream byte; the first byte of each word is bits [31:24].
in_ready  output  1  loader can accept a byte this cycle.
we  output  1  instruction-memory write enable, one cycle per word.
waddr  output  32  byte address for the write, word aligned.
wd  output  32  write data.
busy  output  1  high in RECV and WRITE; drives the core stall/hold.
done  output  1  high in DONE.
err  output  1  last start requested num_words > DEPTH; held until the next start.
words_written  output  CNT_W  count of words written in the current or last load.

Behaviour:
- States: IDLE, RECV, WRITE, DONE.
- All outputs are registered.
- Reset values: state=IDLE; in_ready, we, busy, done, err = 0; waddr, wd = 0; words_written = 0; byte index = 0.
- IDLE or DONE with start=1:
  - Latch num_words, clear words_written, clear err, clear the byte index.
  - num_words == 0 → DONE next cycle; no writes.
  - num_words > DEPTH → err=1, DONE next cycle; no writes.
  - Otherwise → RECV.
- RECV:
  - in_ready=1.
  - A byte is accepted only when in_valid && in_ready.
  - Bytes shift into the word MSB-first; the byte index counts 0..3.
  - Gaps in in_valid stall the load with no timeout.
  - On the 4th accepted byte → WRITE in the next cycle.
- WRITE (exactly one cycle):
  - we=1, wd = packed word, waddr = BASE_ADDR + 4*words_written.
  - in_ready=0.
  - At the end of the cycle words_written increments.
  - If the new count equals the latched num_words → DONE, else → RECV.
- Throughput: 4 bytes plus 1 write cycle per word; at most 5 cycles per word with in_valid held high.
- DONE:
  - done=1 and busy=0; held until the next start or reset.
  - we stays 0.
- start while RECV or WRITE: ignored; num_words is not resampled.
- waddr arithmetic is 32-bit unsigned; bits [1:0] are always 0.
- we=0 in every state except WRITE.
- Reset mid-load: return to the reset values on the next edge. A partially assembled word is discarded. Words already written remain in memory.
- Reset has priority over start.

Test Plan:
1. Basic load:
   - Stimulus: start, num_words=3; bytes 20 08 00 05 20 09 00 0A 01 09 50 20 with in_valid held high.
   - Required: writes (00000000,20080005), (00000004,2009000A), (00000008,01095020).
   - Exactly 3 we pulses, each one cycle; done=1 15 cycles after start; words_written=3.
2. Backpressure:
   - Stimulus: same 3-word stream with in_valid low every other cycle.
   - Required: identical write sequence; no byte lost or duplicated; in_ready=0 on each WRITE cycle.
3. Zero length:
   - Stimulus: start, num_words=0.
   - Required: done=1 next cycle; we never asserts; in_ready stays 0.
4. Overrange:
   - Stimulus: start, num_words=65 with DEPTH=64.
   - Required: err=1 and done=1 next cycle; no we; a following valid start (num_words=1) clears err.
5. Restart and ignored start:
   - Stimulus: start pulse during RECV of word 1; then a second load of 2 words from DONE.
   - Required: the mid-load start has no effect; the second load writes from address 0 again; words_written=2.
6. Reset mid-load:
   - Stimulus: assert reset after 2 bytes of word 1.
   - Required: next edge gives state IDLE, all outputs 0, and no we for the partial word; a new load afterwards packs correctly from byte 0.
